// File: rtl/freq_sweep_ctrl_pkg.sv
// Shared sweep sequencer definitions: FSM state encodings and sweep mode codes.
`ifndef FREQ_SWEEP_DEFS_SV
`define FREQ_SWEEP_DEFS_SV

package freq_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } sweep_state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

endpackage

`endif

// File: rtl/dwell_counter.sv
// Dwell down-counter: counts generator valid strobes, expires on a valid seen at zero.
module dwell_counter #(
    parameter int DWELL_W = 24
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    input  logic               i_clear,
    input  logic               i_gen_valid,
    output logic               o_expire
);

    logic [DWELL_W-1:0] cnt_q;

    assign o_expire = i_gen_valid && (cnt_q == '0);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_clear) begin
            cnt_q <= '0;
        end else if (i_gen_valid && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DWELL_W'(1);
        end
    end

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep sequencer: owns the sine/cosine generator frequency word and enable
// during single, sawtooth or triangle sweeps, stepping once per dwell of valid samples.
module freq_sweep_ctrl
    import freq_sweep_ctrl_pkg::*;
#(
    parameter int FREQ_W  = 12,
    parameter int DWELL_W = 24
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [1:0]         i_mode,
    input  logic [FREQ_W-1:0]  i_f_start,
    input  logic [FREQ_W-1:0]  i_f_stop,
    input  logic [FREQ_W-1:0]  i_f_step,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_gen_valid,
    output logic [FREQ_W-1:0]  o_frequency,
    output logic               o_enable,
    output logic               o_busy,
    output logic               o_step,
    output logic               o_done,
    output logic               o_cfg_err
);

    sweep_state_t       state_q, state_nx;
    logic [FREQ_W-1:0]  freq_q, freq_nx;
    logic               busy_q, step_q, step_nx, done_q, done_nx, err_q, err_nx;
    logic [1:0]         sh_mode_q, sh_mode_nx;
    logic [FREQ_W-1:0]  sh_start_q, sh_start_nx, sh_stop_q, sh_stop_nx, sh_step_q, sh_step_nx;
    logic [DWELL_W-1:0] sh_reload_q, sh_reload_nx;
    logic               cnt_load, cnt_clear, expire;
    logic [DWELL_W-1:0] cnt_load_val;
    logic [FREQ_W:0]    sum_up, diff_dn;
    logic [FREQ_W-1:0]  up_f, dn_f;

    // One extra bit keeps the step arithmetic from wrapping before the clamp.
    assign sum_up  = {1'b0, freq_q} + {1'b0, sh_step_q};
    assign diff_dn = {1'b0, freq_q} - {1'b0, sh_step_q};
    assign up_f    = (sum_up > {1'b0, sh_stop_q}) ? sh_stop_q : sum_up[FREQ_W-1:0];
    assign dn_f    = (diff_dn[FREQ_W] || (diff_dn[FREQ_W-1:0] < sh_start_q))
                     ? sh_start_q : diff_dn[FREQ_W-1:0];

    dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .i_clk       (i_clk),
        .i_arst      (i_arst),
        .i_load      (cnt_load),
        .i_load_val  (cnt_load_val),
        .i_clear     (cnt_clear),
        .i_gen_valid (i_gen_valid),
        .o_expire    (expire)
    );

    always_comb begin
        state_nx     = state_q;
        freq_nx      = freq_q;
        step_nx      = 1'b0;
        done_nx      = 1'b0;
        err_nx       = 1'b0;
        sh_mode_nx   = sh_mode_q;
        sh_start_nx  = sh_start_q;
        sh_stop_nx   = sh_stop_q;
        sh_step_nx   = sh_step_q;
        sh_reload_nx = sh_reload_q;
        cnt_load     = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load_val = sh_reload_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    if ((i_f_step == '0) || (i_f_start > i_f_stop)) begin
                        err_nx = 1'b1;
                    end else begin
                        sh_mode_nx   = i_mode;
                        sh_start_nx  = i_f_start;
                        sh_stop_nx   = i_f_stop;
                        sh_step_nx   = i_f_step;
                        sh_reload_nx = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
                        cnt_load_val = sh_reload_nx;
                        cnt_load     = 1'b1;
                        freq_nx      = i_f_start;
                        step_nx      = 1'b1;
                        state_nx     = ST_UP;
                    end
                end
            end
            ST_UP: begin
                if (i_stop) begin
                    state_nx  = ST_IDLE;
                    cnt_clear = 1'b1;
                end else if (expire) begin
                    step_nx  = 1'b1;
                    cnt_load = 1'b1;
                    if (freq_q < sh_stop_q) begin
                        freq_nx = up_f;
                    end else begin
                        case (sh_mode_q)
                            MODE_SAW: freq_nx = sh_start_q;
                            MODE_TRI: begin
                                freq_nx  = dn_f;
                                state_nx = ST_DOWN;
                            end
                            default: begin
                                step_nx  = 1'b0;
                                cnt_load = 1'b0;
                                done_nx  = 1'b1;
                                state_nx = ST_IDLE;
                            end
                        endcase
                    end
                end
            end
            ST_DOWN: begin
                if (i_stop) begin
                    state_nx  = ST_IDLE;
                    cnt_clear = 1'b1;
                end else if (expire) begin
                    step_nx  = 1'b1;
                    cnt_load = 1'b1;
                    if (freq_q > sh_start_q) begin
                        freq_nx = dn_f;
                    end else begin
                        freq_nx  = up_f;
                        state_nx = ST_UP;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q     <= ST_IDLE;
            freq_q      <= '0;
            busy_q      <= 1'b0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sh_mode_q   <= '0;
            sh_start_q  <= '0;
            sh_stop_q   <= '0;
            sh_step_q   <= '0;
            sh_reload_q <= '0;
        end else begin
            state_q     <= state_nx;
            freq_q      <= freq_nx;
            busy_q      <= (state_nx != ST_IDLE);
            step_q      <= step_nx;
            done_q      <= done_nx;
            err_q       <= err_nx;
            sh_mode_q   <= sh_mode_nx;
            sh_start_q  <= sh_start_nx;
            sh_stop_q   <= sh_stop_nx;
            sh_step_q   <= sh_step_nx;
            sh_reload_q <= sh_reload_nx;
        end
    end

    assign o_frequency = freq_q;
    assign o_enable    = busy_q;
    assign o_busy      = busy_q;
    assign o_step      = step_q;
    assign o_done      = done_q;
    assign o_cfg_err   = err_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed bench for freq_sweep_ctrl: table of sweep configurations plus abort/reset sequences.
module tb_freq_sweep_ctrl;

    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        i_start, i_stop, i_gen_valid;
    logic [1:0]  i_mode;
    logic [11:0] i_f_start, i_f_stop, i_f_step;
    logic [23:0] i_dwell;
    logic [11:0] o_frequency;
    logic        o_enable, o_busy, o_step, o_done, o_cfg_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]       mode;
        logic [11:0]      f_start, f_stop, f_step;
        logic [23:0]      dwell;
        int               period;
        int               n_exp;
        bit               exp_done;
        logic [7:0][11:0] exp_f;
    } vec_t;

    vec_t tbl[8];

    freq_sweep_ctrl #(.FREQ_W(12), .DWELL_W(24)) dut (
        .i_clk       (i_clk),
        .i_arst      (i_arst),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_mode      (i_mode),
        .i_f_start   (i_f_start),
        .i_f_stop    (i_f_stop),
        .i_f_step    (i_f_step),
        .i_dwell     (i_dwell),
        .i_gen_valid (i_gen_valid),
        .o_frequency (o_frequency),
        .o_enable    (o_enable),
        .o_busy      (o_busy),
        .o_step      (o_step),
        .o_done      (o_done),
        .o_cfg_err   (o_cfg_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input int fs, input int fe, input int st,
                                input int dw, input int per, input int n, input bit dn,
                                input int f0, input int f1, input int f2, input int f3,
                                input int f4, input int f5, input int f6, input int f7);
        vec_t v;
        v.mode = mode;  v.f_start = 12'(fs);  v.f_stop = 12'(fe);  v.f_step = 12'(st);
        v.dwell = 24'(dw);  v.period = per;  v.n_exp = n;  v.exp_done = dn;
        v.exp_f[0] = 12'(f0);  v.exp_f[1] = 12'(f1);  v.exp_f[2] = 12'(f2);  v.exp_f[3] = 12'(f3);
        v.exp_f[4] = 12'(f4);  v.exp_f[5] = 12'(f5);  v.exp_f[6] = 12'(f6);  v.exp_f[7] = 12'(f7);
        return v;
    endfunction

    task automatic start_sweep(input logic [1:0] mode, input logic [11:0] fs, input logic [11:0] fe,
                               input logic [11:0] st, input logic [23:0] dw);
        i_mode = mode;  i_f_start = fs;  i_f_stop = fe;  i_f_step = st;  i_dwell = dw;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        // Scrambled inputs must not disturb the running sweep.
        i_mode = 2'd0;  i_f_start = 12'hFFF;  i_f_stop = 12'd0;  i_f_step = 12'd0;  i_dwell = 24'd7;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  dw_eff, nsteps, last_k;
        bit  fin;
        dw_eff = (v.dwell == 0) ? 1 : int'(v.dwell);
        start_sweep(v.mode, v.f_start, v.f_stop, v.f_step, v.dwell);
        chk($sformatf("v%0d_first_step", idx), 32'(o_step), 32'd1);
        chk($sformatf("v%0d_first_freq", idx), 32'(o_frequency), 32'(v.exp_f[0]));
        chk($sformatf("v%0d_busy_en", idx), 32'({o_busy, o_enable}), 32'd3);
        nsteps = 1;  last_k = 0;  fin = 1'b0;
        for (int k = 1; k <= 300 && !fin; k++) begin
            i_gen_valid = ((k % v.period) == 0);
            tick();
            if (o_step) begin
                if (nsteps < v.n_exp) begin
                    chk($sformatf("v%0d_freq%0d", idx, nsteps), 32'(o_frequency), 32'(v.exp_f[nsteps]));
                    chk($sformatf("v%0d_hold%0d", idx, nsteps), 32'(k - last_k), 32'(dw_eff * v.period));
                end else begin
                    chk($sformatf("v%0d_extra_step", idx), 32'(o_step), 32'd0);
                end
                last_k = k;
                nsteps++;
            end
            if (o_done) begin
                chk($sformatf("v%0d_done_expected", idx), 32'(v.exp_done), 32'd1);
                chk($sformatf("v%0d_done_busy", idx), 32'({o_busy, o_enable, o_step}), 32'd0);
                chk($sformatf("v%0d_done_time", idx), 32'(k), 32'(v.n_exp * dw_eff * v.period));
                chk($sformatf("v%0d_done_freq", idx), 32'(o_frequency), 32'(v.exp_f[v.n_exp-1]));
                i_gen_valid = 1'b0;
                tick();
                chk($sformatf("v%0d_done_pulse", idx), 32'({o_done, o_busy}), 32'd0);
                fin = 1'b1;
            end else if (!v.exp_done && nsteps == v.n_exp) begin
                // Abort on a cycle that also carries a valid strobe.
                i_stop = 1'b1;  i_gen_valid = 1'b1;
                tick();
                i_stop = 1'b0;  i_gen_valid = 1'b0;
                chk($sformatf("v%0d_stop_outs", idx), 32'({o_busy, o_enable, o_step, o_done}), 32'd0);
                chk($sformatf("v%0d_stop_freq", idx), 32'(o_frequency), 32'(v.exp_f[v.n_exp-1]));
                fin = 1'b1;
            end
        end
        i_gen_valid = 1'b0;
        if (!fin) chk($sformatf("v%0d_timeout", idx), 32'(fin), 32'd1);
        tick();
    endtask

    initial begin
        i_arst = 1'b1;  i_start = 1'b0;  i_stop = 1'b0;  i_gen_valid = 1'b0;
        i_mode = 2'd0;  i_f_start = '0;  i_f_stop = '0;  i_f_step = '0;  i_dwell = '0;

        tbl[0] = mk(2'd0, 100, 130, 10, 2, 1, 4, 1'b1, 100, 110, 120, 130, 0, 0, 0, 0);
        tbl[1] = mk(2'd0, 100, 125, 10, 1, 1, 4, 1'b1, 100, 110, 120, 125, 0, 0, 0, 0);
        tbl[2] = mk(2'd2, 10, 30, 10, 1, 1, 8, 1'b0, 10, 20, 30, 20, 10, 20, 30, 20);
        tbl[3] = mk(2'd0, 5, 7, 1, 0, 1, 3, 1'b1, 5, 6, 7, 0, 0, 0, 0, 0);
        tbl[4] = mk(2'd1, 0, 4095, 4095, 3, 4, 5, 1'b0, 0, 4095, 0, 4095, 0, 0, 0, 0);
        tbl[5] = mk(2'd3, 0, 20, 15, 1, 1, 3, 1'b1, 0, 15, 20, 0, 0, 0, 0, 0);
        tbl[6] = mk(2'd2, 50, 50, 5, 2, 1, 4, 1'b0, 50, 50, 50, 50, 0, 0, 0, 0);
        tbl[7] = mk(2'd2, 3, 9, 5, 1, 1, 7, 1'b0, 3, 8, 9, 4, 3, 8, 9, 0);

        #12;
        chk("reset_outs", 32'({o_frequency, o_enable, o_busy, o_step, o_done, o_cfg_err}), 32'd0);
        i_arst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

        // Rejected starts.
        i_f_start = 12'd10;  i_f_stop = 12'd20;  i_f_step = 12'd0;  i_dwell = 24'd1;  i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("err_step0", 32'({o_cfg_err, o_busy, o_step}), 32'd4);
        tick();
        chk("err_pulse", 32'(o_cfg_err), 32'd0);
        i_f_start = 12'd50;  i_f_stop = 12'd40;  i_f_step = 12'd1;  i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("err_order", 32'({o_cfg_err, o_busy, o_step}), 32'd4);

        // Start and stop together in IDLE.
        i_f_start = 12'd60;  i_f_stop = 12'd90;  i_f_step = 12'd10;  i_start = 1'b1;  i_stop = 1'b1;
        tick();
        i_start = 1'b0;  i_stop = 1'b0;
        chk("start_stop_idle", 32'({o_cfg_err, o_busy, o_step, o_enable}), 32'd0);

        // Start during a sweep is ignored; shadow config keeps the running sweep.
        start_sweep(2'd0, 12'd100, 12'd130, 12'd10, 24'd1);
        i_start = 1'b1;  i_f_start = 12'd0;  i_f_stop = 12'd4000;  i_f_step = 12'd1;
        tick();
        i_start = 1'b0;
        chk("restart_ignored", 32'({o_step, o_busy, o_frequency}), 32'({1'b0, 1'b1, 12'd100}));
        i_gen_valid = 1'b1;
        tick();
        i_gen_valid = 1'b0;
        chk("shadow_kept", 32'({o_step, o_frequency}), 32'({1'b1, 12'd110}));

        // Asynchronous reset mid-sweep.
        #2 i_arst = 1'b1;
        #1;
        chk("arst_outs", 32'({o_frequency, o_enable, o_busy, o_step, o_done, o_cfg_err}), 32'd0);
        #2 i_arst = 1'b0;
        i_gen_valid = 1'b1;
        repeat (3) tick();
        i_gen_valid = 1'b0;
        chk("post_arst_idle", 32'({o_busy, o_step, o_frequency}), 32'd0);
        start_sweep(2'd1, 12'd200, 12'd300, 12'd50, 24'd1);
        chk("restart_freq", 32'({o_step, o_busy, o_frequency}), 32'({1'b1, 1'b1, 12'd200}));
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        chk("final_stop", 32'({o_busy, o_done, o_frequency}), 32'({1'b0, 1'b0, 12'd200}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
